vec_lane_mem: RTL
=================

VEC_LANE_MEM -- requirements
Module: vec_lane_mem

Interface
REQ-001 SHALL have parameter NO_OF_UNITS, default 8: lanes per memory word.
REQ-002 SHALL have parameter ELEMENT_WIDTH, default 64: bits per lane.
REQ-003 SHALL have parameter DEPTH, default 1001: words stored; need not be a power of two.
REQ-004 SHALL have parameter ADDRESS_WIDTH, default 10: address bits; DEPTH <= 2**ADDRESS_WIDTH.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port write_enable, input, 1: write request.
REQ-008 SHALL have port lane_mask, input, NO_OF_UNITS: per-lane write enable; bit i covers lane i.
REQ-009 SHALL have port input_write_address, input, ADDRESS_WIDTH: write word address.
REQ-010 SHALL have port input_data, input, NO_OF_UNITS*ELEMENT_WIDTH: write data; lane i at bits [i*ELEMENT_WIDTH +: ELEMENT_WIDTH].
REQ-011 SHALL have port read_enable, input, 1: read request.
REQ-012 SHALL have port input_read_address, input, ADDRESS_WIDTH: read word address.
REQ-013 SHALL have port memory_output, output, NO_OF_UNITS*ELEMENT_WIDTH: registered read data.
REQ-014 SHALL have port output_valid, output, 1: memory_output valid this cycle.
REQ-015 SHALL have port dump_start, input, 1: single-cycle request to stream the whole memory out.
REQ-016 SHALL have port dump_busy, output, 1: dump in progress.
REQ-017 SHALL have port dump_valid, output, 1; dump_address, output, ADDRESS_WIDTH; dump_data, output, NO_OF_UNITS*ELEMENT_WIDTH: dump stream.
REQ-018 SHALL have port dump_done, output, 1: one-cycle pulse after the last dump beat.
REQ-019 SHALL have port dirty, output, 1: memory written since reset or since the last completed dump.
REQ-020 SHALL have port write_error, output, 1: one-cycle pulse when a write is dropped.

Function
REQ-021 Write SHALL update only lanes whose lane_mask bit is 1; other lanes keep their value.
REQ-022 A write with input_write_address >= DEPTH SHALL be dropped and SHALL pulse write_error the next cycle.
REQ-023 A write while dump_busy=1 SHALL be dropped and SHALL pulse write_error the next cycle.
REQ-024 A read SHALL have 1-cycle latency: read_enable at cycle N gives memory_output and output_valid=1 at N+1; otherwise output_valid=0 and memory_output holds.
REQ-025 A read with address >= DEPTH SHALL return all zeros with output_valid=1.
REQ-026 A read and an accepted write to the same address in the same cycle SHALL return the merged data: new data in masked lanes, old data elsewhere (write-first).
REQ-027 The dump FSM SHALL have states IDLE, RUN and DONE.
REQ-028 IDLE->RUN on dump_start; dump_busy=1 from the next cycle.
REQ-029 In RUN, the FSM SHALL issue addresses 0..DEPTH-1, one per cycle, with no gaps.
REQ-030 Dump output SHALL be registered: dump_valid, dump_address and dump_data appear 1 cycle after each address is issued.
REQ-031 RUN->DONE after issuing address DEPTH-1; in DONE, dump_done=1 for one cycle, dirty clears, then ->IDLE with dump_busy=0.
REQ-032 dump_start while not IDLE SHALL be ignored.
REQ-033 The user read port SHALL operate independently of the dump (two read ports, one write port).
REQ-034 dirty SHALL set on the cycle after any accepted write, including one with lane_mask all zero.

Reset
REQ-035 rst SHALL force FSM to IDLE and these outputs to 0: memory_output, output_valid, dump_busy, dump_valid, dump_address, dump_data, dump_done, dirty, write_error.
REQ-036 Memory array contents SHALL NOT be reset.
REQ-037 rst asserted mid-dump SHALL abort the dump with no dump_done pulse.

Structure
REQ-038 Package vec_mem_pkg SHALL hold the parameter defaults and the dump FSM state type (IDLE/RUN/DONE).
REQ-039 The dump FSM and address counter SHALL be in sub-module vec_mem_dump_ctrl; array, ports and bypass stay in vec_lane_mem.
REQ-040 The array SHALL be inferable as block RAM except for the bypass mux.

Verification
REQ-041 Masked write: write addr 5, mask 8'hFF, all lanes 64'h1; then addr 5, mask 8'h04, lane 2 = 64'hAB; read 5 -> lane 2 = AB, other lanes = 1, output_valid at N+1.
REQ-042 Collision: write addr 7, mask 8'h01, lane 0 = 64'h55, and read addr 7 in the same cycle -> next-cycle output has lane 0 = 55, other lanes = old data.
REQ-043 Range: write addr 1001 -> write_error pulse, no change; read addr 1001 -> zeros, output_valid=1.
REQ-044 Dump: after writes, pulse dump_start -> 1001 consecutive dump_valid beats, addresses 0..1000, then one dump_done pulse, dirty=0, dump_busy=0.
REQ-045 Dump interference: write during RUN -> write_error pulse, content unchanged; dump_start during RUN -> ignored; user reads return correct data.
REQ-046 Reset mid-dump: assert rst at beat 300 -> all outputs 0 and no dump_done; memory contents intact on later reads.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// Shared defaults and dump FSM state type for the lane-masked vector memory.
package vec_mem_pkg;

  localparam int DEF_NO_OF_UNITS   = 32'sd8;
  localparam int DEF_ELEMENT_WIDTH = 32'sd64;
  localparam int DEF_DEPTH         = 32'sd1001;
  localparam int DEF_ADDRESS_WIDTH = 32'sd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/vec_lane_mem_if.sv
// Bus bundle for vec_lane_mem: user write/read ports, dump stream and status.
interface vec_lane_mem_if
  import vec_mem_pkg::*;
#(
  parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
);

  logic                                   write_enable;
  logic [NO_OF_UNITS-1:0]                 lane_mask;
  logic [ADDRESS_WIDTH-1:0]               input_write_address;
  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   input_data;
  logic                                   read_enable;
  logic [ADDRESS_WIDTH-1:0]               input_read_address;
  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   memory_output;
  logic                                   output_valid;
  logic                                   dump_start;
  logic                                   dump_busy;
  logic                                   dump_valid;
  logic [ADDRESS_WIDTH-1:0]               dump_address;
  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   dump_data;
  logic                                   dump_done;
  logic                                   dirty;
  logic                                   write_error;

  modport master (
    output write_enable, lane_mask, input_write_address, input_data,
    output read_enable, input_read_address, dump_start,
    input  memory_output, output_valid, dump_busy, dump_valid,
    input  dump_address, dump_data, dump_done, dirty, write_error
  );

  modport slave (
    input  write_enable, lane_mask, input_write_address, input_data,
    input  read_enable, input_read_address, dump_start,
    output memory_output, output_valid, dump_busy, dump_valid,
    output dump_address, dump_data, dump_done, dirty, write_error
  );

endinterface

// File: rtl/vec_mem_dump_ctrl.sv
// Dump sequencer: walks addresses 0..DEPTH-1 once per dump_start, then signals DONE.
module vec_mem_dump_ctrl
  import vec_mem_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dump_start,
  output logic                     issue_valid,
  output logic [ADDRESS_WIDTH-1:0] issue_address,
  output logic                     busy,
  output logic                     in_done
);

  localparam int                       LAST_INDEX   = DEPTH - 32'sd1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = LAST_INDEX[ADDRESS_WIDTH-1:0];
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE     = {{(ADDRESS_WIDTH - 32'sd1){1'b0}}, 1'b1};

  dump_state_e              state_r;
  dump_state_e              state_next_s;
  logic [ADDRESS_WIDTH-1:0] count_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Address counter, cleared whenever the sequencer is not issuing
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 count_r <= '0;
    else if (state_r == RUN) count_r <= count_r + ADDR_ONE;
    else                     count_r <= '0;
  end

  // Next-state logic; dump_start outside IDLE has no effect
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (dump_start) state_next_s = RUN;
        else            state_next_s = IDLE;
      end
      RUN: begin
        if (count_r == LAST_ADDRESS) state_next_s = DONE;
        else                         state_next_s = RUN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    issue_valid   = 1'b0;
    busy          = 1'b0;
    in_done       = 1'b0;
    issue_address = count_r;
    case (state_r)
      IDLE: begin
        issue_valid = 1'b0;
        busy        = 1'b0;
      end
      RUN: begin
        issue_valid = 1'b1;
        busy        = 1'b1;
      end
      DONE: begin
        busy    = 1'b1;
        in_done = 1'b1;
      end
      default: begin
        issue_valid = 1'b0;
        busy        = 1'b0;
        in_done     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vec_lane_mem.sv
// Lane-masked vector memory: one write port, one user read port with write-first
// bypass, and a second read port driven by the dump sequencer.
module vec_lane_mem
  import vec_mem_pkg::*;
#(
  parameter int NO_OF_UNITS   = DEF_NO_OF_UNITS,
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input logic           clk,
  input logic           rst,
  vec_lane_mem_if.slave bus
);

  localparam int                     DATA_WIDTH  = NO_OF_UNITS * ELEMENT_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = DEPTH[ADDRESS_WIDTH:0];

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0]  old_data,
    input logic [DATA_WIDTH-1:0]  fresh_data,
    input logic [NO_OF_UNITS-1:0] mask
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_data;
    for (int i = 32'sd0; i < NO_OF_UNITS; i++) begin
      merged[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = mask[i] ? fresh_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]
                                                         : old_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0]    mem_r [DEPTH];
  logic [DATA_WIDTH-1:0]    rd_raw_r;
  logic [DATA_WIDTH-1:0]    dump_raw_r;
  logic [DATA_WIDTH-1:0]    rd_bypass_data_r;
  logic [NO_OF_UNITS-1:0]   rd_bypass_mask_r;
  logic                     rd_valid_r;
  logic                     rd_zero_r;
  logic                     dump_valid_r;
  logic [ADDRESS_WIDTH-1:0] dump_address_r;
  logic                     dump_done_r;
  logic                     dirty_r;
  logic                     write_error_r;

  logic                     wr_in_range_s;
  logic                     rd_in_range_s;
  logic                     wr_accept_s;
  logic                     rd_same_addr_s;
  logic                     issue_valid_s;
  logic [ADDRESS_WIDTH-1:0] issue_address_s;
  logic                     busy_s;
  logic                     in_done_s;

  vec_mem_dump_ctrl #(
    .DEPTH         (DEPTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_dump_ctrl (
    .clk           (clk),
    .rst           (rst),
    .dump_start    (bus.dump_start),
    .issue_valid   (issue_valid_s),
    .issue_address (issue_address_s),
    .busy          (busy_s),
    .in_done       (in_done_s)
  );

  assign wr_in_range_s  = ({1'b0, bus.input_write_address} < DEPTH_LIMIT);
  assign rd_in_range_s  = ({1'b0, bus.input_read_address} < DEPTH_LIMIT);
  assign wr_accept_s    = bus.write_enable && wr_in_range_s && !busy_s;
  assign rd_same_addr_s = wr_accept_s && (bus.input_write_address == bus.input_read_address);

  // Array with per-lane write and two registered read ports; kept reset-free for block RAM
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      for (int i = 32'sd0; i < NO_OF_UNITS; i++) begin
        if (bus.lane_mask[i]) begin
          mem_r[bus.input_write_address][i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <=
            bus.input_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
      end
    end
    if (bus.read_enable && rd_in_range_s) rd_raw_r <= mem_r[bus.input_read_address];
    if (issue_valid_s) dump_raw_r <= mem_r[issue_address_s];
  end

  // User read side: valid flag, out-of-range zeroing and the same-cycle write bypass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r       <= 1'b0;
      rd_zero_r        <= 1'b1;
      rd_bypass_mask_r <= '0;
      rd_bypass_data_r <= '0;
    end else begin
      rd_valid_r <= bus.read_enable;
      if (bus.read_enable) begin
        rd_zero_r        <= !rd_in_range_s;
        rd_bypass_mask_r <= rd_same_addr_s ? bus.lane_mask : '0;
        rd_bypass_data_r <= bus.input_data;
      end
    end
  end

  // Dump stream, dirty tracking and dropped-write flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_valid_r   <= 1'b0;
      dump_address_r <= '0;
      dump_done_r    <= 1'b0;
      dirty_r        <= 1'b0;
      write_error_r  <= 1'b0;
    end else begin
      dump_valid_r  <= issue_valid_s;
      dump_done_r   <= in_done_s;
      write_error_r <= bus.write_enable && !wr_accept_s;
      if (issue_valid_s) dump_address_r <= issue_address_s;
      if (wr_accept_s)    dirty_r <= 1'b1;
      else if (in_done_s) dirty_r <= 1'b0;
    end
  end

  // The bypass merge sits after the array's read register, outside the RAM
  assign bus.memory_output = rd_zero_r ? '0 : merge_lanes(rd_raw_r, rd_bypass_data_r, rd_bypass_mask_r);
  assign bus.output_valid  = rd_valid_r;
  assign bus.dump_busy     = busy_s;
  assign bus.dump_valid    = dump_valid_r;
  assign bus.dump_address  = dump_address_r;
  assign bus.dump_data     = dump_valid_r ? dump_raw_r : '0;
  assign bus.dump_done     = dump_done_r;
  assign bus.dirty         = dirty_r;
  assign bus.write_error   = write_error_r;

endmodule
